i_stream_buffer: RTL and testbench
==================================

I_STREAM_BUFFER -- requirements
Module: i_stream_buffer

Interface
REQ-001 Parameter SB_DEPTH, default 4: number of line entries; power of two, minimum 2.
REQ-002 Parameter BLOCK_OFFSET_WIDTH, default 2: words per line is LINE_SIZE = 2^BLOCK_OFFSET_WIDTH, maximum 8.
REQ-003 Derived LINE_ADDR_W = `ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2: 22 bits with the defaults.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 miss_valid  in  1  one-cycle pulse; the I-cache has missed.
REQ-007 miss_line  in  LINE_ADDR_W  line address of the missing line.
REQ-008 lookup_line  in  LINE_ADDR_W  line address of the current fetch PC.
REQ-009 lookup_offset  in  BLOCK_OFFSET_WIDTH  word offset of the current fetch PC.
REQ-010 sb_hit  out  1  head entry is complete and matches lookup_line.
REQ-011 sb_word  out  `DATA_WIDTH  head word selected by lookup_offset.
REQ-012 sb_line  out  LINE_SIZE*`DATA_WIDTH  all head words; word 0 in the LSBs.
REQ-013 pop  in  1  cache has consumed the head line.
REQ-014 mem_read_address  axi_read_address.master  ARADDR/ARLEN/ARVALID out, ARREADY in, ARID out.
REQ-015 mem_read_data  axi_read_data.master  RDATA/RVALID in, RREADY out.

Function
REQ-016 Storage: circular FIFO of SB_DEPTH entries, each holding line address, LINE_SIZE words and a complete flag; head pointer, tail pointer and count.
REQ-017 sb_hit = (count>0) & head complete & (head line == lookup_line); combinational, no added latency; 0 otherwise.
REQ-018 sb_word = head word[lookup_offset]; sb_line = head words; the value is don't-care when sb_hit=0.
REQ-019 pop with sb_hit=1 retires the head at the next edge (head+1 mod SB_DEPTH, count-1); pop with sb_hit=0 is ignored.
REQ-020 Internal active flag: 0 after reset; set by the first miss_valid. No prefetch is issued while active=0.
REQ-021 miss_valid with (sb_hit=1 and lookup_line==miss_line): no action.
REQ-022 Any other miss_valid flushes the buffer at the next edge: count=0, head=tail, next_pf = miss_line+1 modulo 2^LINE_ADDR_W, active=1.
REQ-023 Simultaneous miss_valid and pop: the flush wins and the pop is discarded.
REQ-024 FSM states are IDLE, REQ, DATA, DRAIN; reset state is IDLE.
REQ-025 IDLE->REQ: taken when active=1, no flush this cycle, and count < SB_DEPTH. The tail entry is allocated with line=next_pf and complete=0.
REQ-026 REQ: ARVALID=1, ARADDR={next_pf, (BLOCK_OFFSET_WIDTH+2) zero bits}, ARLEN=LINE_SIZE, ARID=4'd1. These values are held stable until ARREADY. On ARREADY the FSM goes to DATA and the beat counter clears.
REQ-027 DATA: each RVALID beat writes RDATA to word[beat] of the tail entry and increments the beat counter.
REQ-028 DATA: on beat LINE_SIZE-1 the entry is marked complete, tail+1, count+1, next_pf+1 (wraps), and the FSM returns to IDLE.
REQ-029 RREADY is 1 in every state, including reset.
REQ-030 Flush in REQ: ARVALID is not dropped; after ARREADY the FSM goes to DRAIN.
REQ-031 Flush in DATA: go to DRAIN; the beat counter continues counting.
REQ-032 DRAIN: beats are counted but discarded (no entry written). After beat LINE_SIZE-1 the FSM goes to IDLE, and prefetch resumes from the post-flush next_pf.
REQ-033 A line under fill is not visible to sb_hit and is not counted in count. Count never exceeds SB_DEPTH.
REQ-034 Full (count==SB_DEPTH): stay in IDLE. A pop frees one entry, and REQ may be entered the cycle after that pop.
REQ-035 A second miss_valid during DRAIN updates next_pf only; the drain completes normally.

Reset
REQ-036 rst=1 at an edge forces: state=IDLE, count=0, head=tail=0, active=0, all complete flags=0, beat counter=0, sb_hit=0, ARVALID=0, RREADY=1.
REQ-037 Reset takes effect mid-transfer. Stray R beats after reset are ignored while in IDLE.

Verification
REQ-038 Reset, then idle for 20 cycles -> ARVALID=0, sb_hit=0 throughout.
REQ-039 miss_valid with miss_line=0x100, memory ARREADY=1, 4-beat responses -> ARADDR sequence 0x1010, 0x1020, 0x1030, 0x1040, then ARVALID stays 0 (full, SB_DEPTH=4).
REQ-040 Buffer full, lookup_line=0x101, lookup_offset=2 -> sb_hit=1 and sb_word=third beat of the first response. Then pop -> the next cycle ARVALID=1 with ARADDR=0x1050.
REQ-041 miss_valid miss_line=0x200 at beat 1 of a fill -> beats 2-3 discarded; next ARADDR=0x2010; sb_hit=0 for lookup_line=0x105.
REQ-042 miss_line=0x3FFFFF -> first prefetch ARADDR=0x000000 (wrap).
REQ-043 miss_valid and pop in the same cycle -> count=0 the next cycle, with no stale hit.

Source files
------------

// File: rtl/i_stream_buffer_if.sv
// ============================================================================
// Module      : axi_read_address / axi_read_data
// Description : AXI-style read address and read data channel bundles used
//               by the instruction stream buffer to fetch cache lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface axi_read_address #(
  parameter int ADDR_W = `ADDR_WIDTH
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [3:0]        arid;

  modport master (output araddr, arlen, arvalid, arid, input arready);
  modport slave  (input araddr, arlen, arvalid, arid, output arready);
endinterface

interface axi_read_data #(
  parameter int DATA_W = `DATA_WIDTH
);
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  modport master (input rdata, rvalid, output rready);
  modport slave  (output rdata, rvalid, input rready);
endinterface

`default_nettype wire

// File: rtl/i_stream_buffer.sv
// ============================================================================
// Module      : i_stream_buffer
// Description : Sequential-line instruction prefetch buffer. After an I-cache
//               miss it prefetches the following lines into a circular FIFO
//               and offers the head line to the cache on a lookup match.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i_stream_buffer #(
  parameter int SB_DEPTH           = 4,
  parameter int BLOCK_OFFSET_WIDTH = 2,
  localparam int LINE_SIZE         = 1 << BLOCK_OFFSET_WIDTH,
  localparam int LINE_ADDR_W       = `ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              miss_valid,
  input  logic [LINE_ADDR_W-1:0]            miss_line,
  input  logic [LINE_ADDR_W-1:0]            lookup_line,
  input  logic [BLOCK_OFFSET_WIDTH-1:0]     lookup_offset,
  output logic                              sb_hit,
  output logic [`DATA_WIDTH-1:0]            sb_word,
  output logic [LINE_SIZE*`DATA_WIDTH-1:0]  sb_line,
  input  logic                              pop,
  axi_read_address.master                   mem_read_address,
  axi_read_data.master                      mem_read_data
);

  localparam int c_DATA_W = `DATA_WIDTH;
  localparam int c_PTR_W  = $clog2(SB_DEPTH);
  localparam logic [c_PTR_W:0]              c_FULL      = (c_PTR_W+1)'(SB_DEPTH);
  localparam logic [BLOCK_OFFSET_WIDTH-1:0] c_LAST_BEAT = {BLOCK_OFFSET_WIDTH{1'b1}};

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_REQ   = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_DRAIN = 2'd3;

  logic [1:0]                    r_state;
  logic [c_PTR_W-1:0]            r_head;
  logic [c_PTR_W-1:0]            r_tail;
  logic [c_PTR_W:0]              r_count;
  logic [LINE_ADDR_W-1:0]        r_next_pf;
  logic                          r_active;
  logic                          r_req_flushed;
  logic [BLOCK_OFFSET_WIDTH-1:0] r_beat;

  logic [LINE_ADDR_W-1:0]        r_line     [SB_DEPTH];
  logic                          r_complete [SB_DEPTH];
  logic [c_DATA_W-1:0]           r_data     [SB_DEPTH][LINE_SIZE];

  logic w_flush;
  logic w_pop;
  logic w_beat;
  logic w_last;
  logic w_start;
  logic w_commit;
  logic w_write;

  // Head-entry match and the control events that drive the state updates.
  always_comb begin
    sb_hit   = (r_count != '0) && r_complete[r_head] && (r_line[r_head] == lookup_line);
    // A miss on the very line the buffer is already presenting needs no action.
    w_flush  = miss_valid && !(sb_hit && (lookup_line == miss_line));
    w_pop    = pop && sb_hit && !w_flush;
    w_beat   = mem_read_data.rvalid;
    w_last   = w_beat && (r_beat == c_LAST_BEAT);
    // A pop in the same cycle frees a slot, so a full buffer may still start.
    w_start  = (r_state == c_IDLE) && r_active && !w_flush &&
               ((r_count != c_FULL) || w_pop);
    // A flush that lands on the final beat discards the line being filled.
    w_commit = (r_state == c_DATA) && w_last && !w_flush;
    w_write  = (r_state == c_DATA) && w_beat;
  end

  assign sb_word = r_data[r_head][lookup_offset];

  generate
    for (genvar g = 0; g < LINE_SIZE; g++) begin : g_line
      assign sb_line[g*c_DATA_W +: c_DATA_W] = r_data[r_head][g];
    end
  endgenerate

  assign mem_read_address.arvalid = (r_state == c_REQ);
  // The address comes from the allocated tail entry so a flush cannot change it mid-request.
  assign mem_read_address.araddr  = {r_line[r_tail], {(BLOCK_OFFSET_WIDTH+2){1'b0}}};
  assign mem_read_address.arlen   = 8'(LINE_SIZE);
  assign mem_read_address.arid    = 4'd1;
  assign mem_read_data.rready     = 1'b1;

  // Prefetch FSM, beat counter, FIFO pointers and the prefetch line address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_next_pf     <= '0;
      r_active      <= 1'b0;
      r_req_flushed <= 1'b0;
      r_beat        <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_start) r_state <= c_REQ;
        end
        c_REQ: begin
          if (mem_read_address.arready) begin
            r_beat        <= '0;
            r_req_flushed <= 1'b0;
            r_state       <= (r_req_flushed || w_flush) ? c_DRAIN : c_DATA;
          end else if (w_flush) begin
            r_req_flushed <= 1'b1;
          end
        end
        c_DATA: begin
          if (w_beat) r_beat <= r_beat + 1'b1;
          if (w_last)       r_state <= c_IDLE;
          else if (w_flush) r_state <= c_DRAIN;
        end
        default: begin
          if (w_beat) r_beat <= r_beat + 1'b1;
          if (w_last) r_state <= c_IDLE;
        end
      endcase

      if (w_flush) begin
        r_count   <= '0;
        r_head    <= r_tail;
        r_next_pf <= miss_line + 1'b1;
        r_active  <= 1'b1;
      end else begin
        if (w_pop) r_head <= r_head + 1'b1;
        if (w_commit) begin
          r_tail    <= r_tail + 1'b1;
          r_next_pf <= r_next_pf + 1'b1;
        end
        case ({w_commit, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry tags and completion flags: allocated on request start, set on the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) r_complete[i] <= 1'b0;
    end else begin
      if (w_start) begin
        r_line[r_tail]     <= r_next_pf;
        r_complete[r_tail] <= 1'b0;
      end
      if (w_commit) r_complete[r_tail] <= 1'b1;
    end
  end

  // Line data capture into the tail entry while it is being filled.
  always_ff @(posedge clk) begin
    if (w_write && !rst) r_data[r_tail][r_beat] <= mem_read_data.rdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_i_stream_buffer.sv
// ============================================================================
// Module      : tb_i_stream_buffer
// Description : Self-checking bench for i_stream_buffer: directed table,
//               hand-written corner sequences and randomized traffic against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i_stream_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic [21:0]  miss_line;
  logic [21:0]  lookup_line;
  logic [1:0]   lookup_offset;
  logic         pop;
  logic         sb_hit;
  logic [31:0]  sb_word;
  logic [127:0] sb_line;

  axi_read_address ar_if ();
  axi_read_data    rd_if ();

  i_stream_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .miss_valid       (miss_valid),
    .miss_line        (miss_line),
    .lookup_line      (lookup_line),
    .lookup_offset    (lookup_offset),
    .sb_hit           (sb_hit),
    .sb_word          (sb_word),
    .sb_line          (sb_line),
    .pop              (pop),
    .mem_read_address (ar_if),
    .mem_read_data    (rd_if)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: completed lines as a queue plus the line being fetched.
  logic [21:0] m_q[$];
  logic [21:0] m_next_pf;
  logic        m_active;
  logic        m_fill;
  logic [21:0] m_fill_line;
  logic        m_ar_done;
  int          m_beats;
  logic        m_discard;

  // Values sampled by the most recent step.
  logic        s_hit, s_arv, s_rready;
  logic [25:0] s_addr;
  logic [31:0] s_word;

  function automatic logic [31:0] word_of(input logic [21:0] line, input int idx);
    return {2'b00, line, 8'(idx)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_next_pf = '0;
    m_active  = 1'b0;
    m_fill    = 1'b0;
    m_fill_line = '0;
    m_ar_done = 1'b0;
    m_beats   = 0;
    m_discard = 1'b0;
  endtask

  task automatic model_update(input logic rs, mv, input logic [21:0] ml, input logic pp,
                              input logic [21:0] ll, input logic ar, rv);
    logic hit, flush, popd, was_fill, can_start, commit;
    if (rs) begin
      model_reset();
      return;
    end
    hit       = (m_q.size() > 0) && (m_q[0] == ll);
    flush     = mv && !(hit && (ll == ml));
    popd      = pp && hit && !flush;
    was_fill  = m_fill;
    can_start = !was_fill && m_active && !flush && ((m_q.size() < 4) || popd);
    commit    = 1'b0;
    if (was_fill) begin
      if (!m_ar_done) begin
        if (ar) begin
          m_ar_done = 1'b1;
          m_beats   = 0;
        end
      end else if (rv) begin
        m_beats++;
        if (m_beats == 4) begin
          m_fill = 1'b0;
          commit = !m_discard && !flush;
        end
      end
      if (flush && m_fill) m_discard = 1'b1;
    end
    if (popd) void'(m_q.pop_front());
    if (commit) begin
      m_q.push_back(m_fill_line);
      m_next_pf = m_next_pf + 22'd1;
    end
    if (flush) begin
      m_q.delete();
      m_next_pf = ml + 22'd1;
      m_active  = 1'b1;
    end
    if (can_start) begin
      m_fill      = 1'b1;
      m_fill_line = m_next_pf;
      m_ar_done   = 1'b0;
      m_discard   = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic rs, mv, input logic [21:0] ml, input logic pp,
                      input logic [21:0] ll, input logic [1:0] off, input logic ar, rv);
    logic         e_hit;
    logic [127:0] e_line;
    @(negedge clk);
    rst           = rs;
    miss_valid    = mv;
    miss_line     = ml;
    pop           = pp;
    lookup_line   = ll;
    lookup_offset = off;
    ar_if.arready = ar;
    rd_if.rvalid  = rv;
    rd_if.rdata   = (m_fill && m_ar_done) ? word_of(m_fill_line, m_beats) : $urandom;
    #1;
    s_hit    = sb_hit;
    s_arv    = ar_if.arvalid;
    s_addr   = ar_if.araddr;
    s_word   = sb_word;
    s_rready = rd_if.rready;
    e_hit = (m_q.size() > 0) && (m_q[0] == ll);
    chk("arvalid", {127'd0, ar_if.arvalid}, {127'd0, m_fill && !m_ar_done});
    chk("sb_hit", {127'd0, sb_hit}, {127'd0, e_hit});
    chk("rready", {127'd0, rd_if.rready}, 128'd1);
    if (m_fill && !m_ar_done) begin
      chk("araddr", {102'd0, ar_if.araddr}, {102'd0, m_fill_line, 4'b0000});
      chk("arlen", {120'd0, ar_if.arlen}, 128'd4);
      chk("arid", {124'd0, ar_if.arid}, 128'd1);
    end
    if (e_hit) begin
      for (int i = 0; i < 4; i++) e_line[i*32 +: 32] = word_of(m_q[0], i);
      chk("sb_word", {96'd0, sb_word}, {96'd0, word_of(m_q[0], int'(off))});
      chk("sb_line", sb_line, e_line);
    end
    model_update(rs, mv, ml, pp, ll, ar, rv);
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic ar, rv);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, ar, rv);
  endtask

  typedef struct {
    int          n;
    logic        mv;
    logic [21:0] ml;
    logic        pp;
    logic [21:0] ll;
    logic [1:0]  off;
    logic        exp_arv;
    logic [25:0] exp_addr;
    logic        exp_hit;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tv[14];

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_line = '0; pop = 1'b0;
    lookup_line = '0; lookup_offset = '0;
    ar_if.arready = 1'b0; rd_if.rvalid = 1'b0; rd_if.rdata = '0;
    model_reset();

    // Full-fill, pop-refill and flush-during-fill scenario with an always-ready memory.
    tv[0]  = '{1,  1'b1, 22'h100, 1'b0, 22'h000, 2'd0, 1'b0, 26'h0,    1'b0, 32'h0};
    tv[1]  = '{2,  1'b0, 22'h000, 1'b0, 22'h000, 2'd0, 1'b1, 26'h1010, 1'b0, 32'h0};
    tv[2]  = '{6,  1'b0, 22'h000, 1'b0, 22'h000, 2'd0, 1'b1, 26'h1020, 1'b0, 32'h0};
    tv[3]  = '{6,  1'b0, 22'h000, 1'b0, 22'h000, 2'd0, 1'b1, 26'h1030, 1'b0, 32'h0};
    tv[4]  = '{6,  1'b0, 22'h000, 1'b0, 22'h000, 2'd0, 1'b1, 26'h1040, 1'b0, 32'h0};
    tv[5]  = '{10, 1'b0, 22'h000, 1'b0, 22'h101, 2'd2, 1'b0, 26'h0,    1'b1, 32'h00010102};
    tv[6]  = '{1,  1'b0, 22'h000, 1'b1, 22'h101, 2'd2, 1'b0, 26'h0,    1'b1, 32'h00010102};
    tv[7]  = '{1,  1'b0, 22'h000, 1'b0, 22'h102, 2'd0, 1'b1, 26'h1050, 1'b1, 32'h00010200};
    tv[8]  = '{1,  1'b0, 22'h000, 1'b0, 22'h102, 2'd0, 1'b0, 26'h0,    1'b1, 32'h00010200};
    tv[9]  = '{1,  1'b1, 22'h200, 1'b0, 22'h105, 2'd0, 1'b0, 26'h0,    1'b0, 32'h0};
    tv[10] = '{1,  1'b0, 22'h000, 1'b0, 22'h105, 2'd0, 1'b0, 26'h0,    1'b0, 32'h0};
    tv[11] = '{1,  1'b0, 22'h000, 1'b0, 22'h105, 2'd0, 1'b0, 26'h0,    1'b0, 32'h0};
    tv[12] = '{1,  1'b0, 22'h000, 1'b0, 22'h105, 2'd0, 1'b0, 26'h0,    1'b0, 32'h0};
    tv[13] = '{1,  1'b0, 22'h000, 1'b0, 22'h105, 2'd0, 1'b1, 26'h2010, 1'b0, 32'h0};

    // Reset state, then a quiet period with no prefetch activity.
    step(1'b1, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    chk("reset_arvalid", {127'd0, s_arv}, 128'd0);
    chk("reset_hit", {127'd0, s_hit}, 128'd0);
    chk("reset_rready", {127'd0, s_rready}, 128'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, 1'b1, 1'b1);
      chk("idle_arvalid", {127'd0, s_arv}, 128'd0);
      chk("idle_hit", {127'd0, s_hit}, 128'd0);
    end

    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < tv[r].n; k++)
        step(1'b0, tv[r].mv, tv[r].ml, tv[r].pp, tv[r].ll, tv[r].off, 1'b1, 1'b1);
      chk($sformatf("tv%0d_arvalid", r), {127'd0, s_arv}, {127'd0, tv[r].exp_arv});
      chk($sformatf("tv%0d_hit", r), {127'd0, s_hit}, {127'd0, tv[r].exp_hit});
      if (tv[r].exp_arv) chk($sformatf("tv%0d_araddr", r), {102'd0, s_addr}, {102'd0, tv[r].exp_addr});
      if (tv[r].exp_hit) chk($sformatf("tv%0d_word", r), {96'd0, s_word}, {96'd0, tv[r].exp_word});
    end

    // Line address wraps to zero after the top line.
    step(1'b1, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 22'h3FFFFF, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    chk("wrap_arvalid", {127'd0, s_arv}, 128'd1);
    chk("wrap_araddr", {102'd0, s_addr}, 128'd0);

    // Flush while the address is stalled: address held, request drained, restart from new line.
    step(1'b1, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 22'h050, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 22'h070, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    chk("stall_araddr0", {102'd0, s_addr}, 128'h510);
    step(1'b0, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    chk("stall_arvalid", {127'd0, s_arv}, 128'd1);
    chk("stall_araddr1", {102'd0, s_addr}, 128'h510);
    step(1'b0, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, 1'b1, 1'b0);
    idle(4, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);
    chk("drain_arvalid", {127'd0, s_arv}, 128'd1);
    chk("drain_araddr", {102'd0, s_addr}, 128'h710);

    // Miss and pop in the same cycle: flush wins, no stale hit afterwards.
    step(1'b1, 1'b0, 22'd0, 1'b0, 22'd0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 22'h010, 1'b0, 22'd0, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 22'd0, 1'b0, 22'h011, 2'd1, 1'b1, 1'b1);
    chk("mp_hit_before", {127'd0, s_hit}, 128'd1);
    step(1'b0, 1'b1, 22'h040, 1'b1, 22'h011, 2'd1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 22'd0, 1'b0, 22'h011, 2'd1, 1'b1, 1'b1);
    chk("mp_hit_after", {127'd0, s_hit}, 128'd0);

    // Randomized traffic, including resets mid-transfer and stray read beats.
    for (int c = 0; c < 4000; c++) begin
      logic        rs, mv, pp, ar, rv;
      logic [21:0] ml, ll, head;
      logic [1:0]  off;
      rs   = ($urandom_range(0, 399) == 0);
      mv   = ($urandom_range(0, 29) == 0);
      head = (m_q.size() > 0) ? m_q[0] : 22'($urandom_range(0, 15));
      ll   = ($urandom_range(0, 3) != 0) ? head : head + 22'($urandom_range(1, 2));
      case ($urandom_range(0, 3))
        0:       ml = ll;
        1:       ml = 22'h3FFFFF;
        default: ml = 22'($urandom_range(0, 255));
      endcase
      pp  = ($urandom_range(0, 2) == 0);
      off = 2'($urandom_range(0, 3));
      ar  = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 3) != 0);
      step(rs, mv, ml, pp, ll, off, ar, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
